// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: target end of the host-initiated serial command protocol.
// Parses SOM-framed commands from uart_rx bytes, updates the motor control
// registers, pulses encoder-zero and streams 5-byte encoder replies to uart_tx.
//
// Ports:
//   clk_100MHz, rst_n         clock, async active-low reset
//   i_rx_dv, i_rx_byte        received byte strobe and data
//   o_tx_dv, o_tx_byte        transmit byte strobe and data to uart_tx
//   i_tx_done                 uart_tx finished the current byte
//   i_enc_cnt_l, i_enc_cnt_r  encoder counts sampled for replies
//   o_setpt1, o_setpt2        left/right speed setpoints (0x80 = stop)
//   o_accel, o_tics_per_rev   acceleration and encoder resolution settings
//   o_zero_encoders           one-cycle encoder clear pulse
//   o_busy                    reply in progress
//   o_err                     one-cycle protocol error pulse
module uart_cmd_responder #(
    parameter logic [7:0]  SOM_BYTE     = 8'h55,
    parameter int unsigned TIMEOUT_CLKS = 1000000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             i_rx_dv,
    input  logic [7:0]       i_rx_byte,
    output logic             o_tx_dv,
    output logic [7:0]       o_tx_byte,
    input  logic             i_tx_done,
    input  logic [CNT_W-1:0] i_enc_cnt_l,
    input  logic [CNT_W-1:0] i_enc_cnt_r,
    output logic [7:0]       o_setpt1,
    output logic [7:0]       o_setpt2,
    output logic [7:0]       o_accel,
    output logic [15:0]      o_tics_per_rev,
    output logic             o_zero_encoders,
    output logic             o_busy,
    output logic             o_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_PAY1    = 3'd2;
    localparam logic [2:0] S_PAY2    = 3'd3;
    localparam logic [2:0] S_TX_SEND = 3'd4;
    localparam logic [2:0] S_TX_WAIT = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       hi_q, hi_d;
    logic [23:0]      snap_q, snap_d;
    logic [2:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       setpt1_q, setpt1_d, setpt2_q, setpt2_d, accel_q, accel_d;
    logic [15:0]      tics_q, tics_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             zero_q, zero_d, err_q, err_d;
    logic             in_frame, timeout;

    // Frame timeout only runs while a command is partially received; any rx byte restarts it.
    assign in_frame = (state_q == S_CMD) || (state_q == S_PAY1) || (state_q == S_PAY2);
    assign timeout  = in_frame && !i_rx_dv && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        hi_d      = hi_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        setpt1_d  = setpt1_q;
        setpt2_d  = setpt2_q;
        accel_d   = accel_q;
        tics_d    = tics_q;
        tx_byte_d = tx_byte_q;
        zero_d    = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (in_frame && !i_rx_dv) ? tmo_q + 1'b1 : '0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_dv && i_rx_byte == SOM_BYTE) state_d = S_CMD;
            end
            S_CMD: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (i_rx_dv) begin
                    if (i_rx_byte == SOM_BYTE) begin
                        state_d = S_CMD;  // resync on repeated SOM
                    end else begin
                        case (i_rx_byte)
                            8'h11, 8'h21, 8'h22, 8'h23: begin
                                cmd_d   = i_rx_byte;
                                state_d = S_PAY1;
                            end
                            8'h24, 8'h25: begin
                                // Snapshot here so encoder motion during the reply is invisible.
                                snap_d    = (i_rx_byte == 8'h24) ? 24'(i_enc_cnt_l)
                                                                 : 24'(i_enc_cnt_r);
                                cmd_d     = i_rx_byte;
                                idx_d     = 3'd0;
                                tx_byte_d = SOM_BYTE;
                                state_d   = S_TX_SEND;
                            end
                            8'h26: begin
                                zero_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end
            S_PAY1: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (i_rx_dv) begin
                    state_d = S_IDLE;
                    case (cmd_q)
                        8'h11: begin
                            hi_d    = i_rx_byte;
                            state_d = S_PAY2;
                        end
                        8'h21:   setpt1_d = i_rx_byte;
                        8'h22:   setpt2_d = i_rx_byte;
                        default: accel_d  = i_rx_byte;
                    endcase
                end
            end
            S_PAY2: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (i_rx_dv) begin
                    tics_d  = {hi_q, i_rx_byte};
                    state_d = S_IDLE;
                end
            end
            S_TX_SEND: begin
                if (i_rx_dv) err_d = 1'b1;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (i_rx_dv) err_d = 1'b1;
                if (i_tx_done) begin
                    if (idx_q == 3'd4) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_TX_SEND;
                        case (idx_q)
                            3'd0:    tx_byte_d = cmd_q;
                            3'd1:    tx_byte_d = snap_q[23:16];
                            3'd2:    tx_byte_d = snap_q[15:8];
                            default: tx_byte_d = snap_q[7:0];
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            hi_q      <= '0;
            snap_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            setpt1_q  <= 8'h80;
            setpt2_q  <= 8'h80;
            accel_q   <= '0;
            tics_q    <= '0;
            tx_byte_q <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            hi_q      <= hi_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            setpt1_q  <= setpt1_d;
            setpt2_q  <= setpt2_d;
            accel_q   <= accel_d;
            tics_q    <= tics_d;
            tx_byte_q <= tx_byte_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
        end
    end

    assign o_tx_dv         = (state_q == S_TX_SEND);
    assign o_busy          = (state_q == S_TX_SEND) || (state_q == S_TX_WAIT);
    assign o_tx_byte       = tx_byte_q;
    assign o_setpt1        = setpt1_q;
    assign o_setpt2        = setpt2_q;
    assign o_accel         = accel_q;
    assign o_tics_per_rev  = tics_q;
    assign o_zero_encoders = zero_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

    localparam int unsigned TMO = 40;

    logic        clk_100MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx_dv = 1'b0;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        i_tx_done = 1'b0;
    logic [23:0] i_enc_cnt_l = 24'h0;
    logic [23:0] i_enc_cnt_r = 24'h0;
    logic [7:0]  o_setpt1, o_setpt2, o_accel;
    logic [15:0] o_tics_per_rev;
    logic        o_zero_encoders, o_busy, o_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int zero_seen = 0;
    int dv_seen = 0;
    int base_err, base_zero, base_dv;

    uart_cmd_responder #(
        .SOM_BYTE    (8'h55),
        .TIMEOUT_CLKS(TMO),
        .CNT_W       (24)
    ) dut (
        .clk_100MHz     (clk_100MHz),
        .rst_n          (rst_n),
        .i_rx_dv        (i_rx_dv),
        .i_rx_byte      (i_rx_byte),
        .o_tx_dv        (o_tx_dv),
        .o_tx_byte      (o_tx_byte),
        .i_tx_done      (i_tx_done),
        .i_enc_cnt_l    (i_enc_cnt_l),
        .i_enc_cnt_r    (i_enc_cnt_r),
        .o_setpt1       (o_setpt1),
        .o_setpt2       (o_setpt2),
        .o_accel        (o_accel),
        .o_tics_per_rev (o_tics_per_rev),
        .o_zero_encoders(o_zero_encoders),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Pulse counters sampled on the active edge (pre-update values).
    always @(posedge clk_100MHz) begin
        if (o_err) err_seen <= err_seen + 1;
        if (o_zero_encoders) zero_seen <= zero_seen + 1;
        if (o_tx_dv) dv_seen <= dv_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_100MHz);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(negedge clk_100MHz);
        i_rx_dv   = 1'b0;
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        @(negedge clk_100MHz);
        i_tx_done = 1'b0;
    endtask

    // Called at the negedge where o_tx_dv should be high for this byte.
    task automatic reply_step(input string tag, input logic [7:0] exp, input bit inj,
                              input logic [7:0] ib);
        check({tag, "_dv"}, 32'(o_tx_dv), 32'd1);
        check({tag, "_byte"}, 32'(o_tx_byte), 32'(exp));
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        @(negedge clk_100MHz);
        check({tag, "_dv_low"}, 32'(o_tx_dv), 32'd0);
        if (inj) send_byte(ib);
        else @(negedge clk_100MHz);
        pulse_done();
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_setpt1", 32'(o_setpt1), 32'h80);
        check("rst_setpt2", 32'(o_setpt2), 32'h80);
        check("rst_accel", 32'(o_accel), 32'h0);
        check("rst_tics", 32'(o_tics_per_rev), 32'h0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_tx_dv", 32'(o_tx_dv), 32'd0);
        check("rst_tx_byte", 32'(o_tx_byte), 32'h0);
        check("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 55 21 C0
        base_err = err_seen;
        send_byte(8'h55);
        send_byte(8'h21);
        send_byte(8'hC0);
        check("sp1_set", 32'(o_setpt1), 32'hC0);
        check("sp1_sp2_same", 32'(o_setpt2), 32'h80);
        idle(2);
        check("sp1_no_err", 32'(err_seen - base_err), 32'd0);

        // 55 11 01 F4, no partial value visible
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h01);
        idle(2);
        check("tics_partial", 32'(o_tics_per_rev), 32'h0);
        send_byte(8'hF4);
        check("tics_full", 32'(o_tics_per_rev), 32'h01F4);

        // 55 23 07
        send_byte(8'h55);
        send_byte(8'h23);
        send_byte(8'h07);
        check("accel", 32'(o_accel), 32'h07);
        idle(2);

        // Get left encoder, count changes during reply
        i_enc_cnt_l = 24'h12AB34;
        check("pre_reply_busy", 32'(o_busy), 32'd0);
        send_byte(8'h55);
        send_byte(8'h24);
        i_enc_cnt_l = 24'h0;
        reply_step("l0", 8'h55, 1'b0, 8'h00);
        reply_step("l1", 8'h24, 1'b0, 8'h00);
        reply_step("l2", 8'h12, 1'b0, 8'h00);
        reply_step("l3", 8'hAB, 1'b0, 8'h00);
        reply_step("l4", 8'h34, 1'b0, 8'h00);
        check("l_done_busy", 32'(o_busy), 32'd0);
        check("l_done_dv", 32'(o_tx_dv), 32'd0);
        idle(2);

        // 55 55 26 -> one zero pulse, no error
        base_err  = err_seen;
        base_zero = zero_seen;
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'h26);
        idle(3);
        check("zero_pulse", 32'(zero_seen - base_zero), 32'd1);
        check("zero_no_err", 32'(err_seen - base_err), 32'd0);

        // 55 7F -> error, registers unchanged
        base_err = err_seen;
        send_byte(8'h55);
        send_byte(8'h7F);
        idle(3);
        check("bad_cmd_err", 32'(err_seen - base_err), 32'd1);
        check("bad_cmd_sp1", 32'(o_setpt1), 32'hC0);
        check("bad_cmd_tics", 32'(o_tics_per_rev), 32'h01F4);

        // 55 22 then silence -> timeout error
        base_err = err_seen;
        send_byte(8'h55);
        send_byte(8'h22);
        idle(TMO - 10);
        check("tmo_not_yet", 32'(err_seen - base_err), 32'd0);
        idle(20);
        check("tmo_err", 32'(err_seen - base_err), 32'd1);
        check("tmo_sp2_kept", 32'(o_setpt2), 32'h80);
        send_byte(8'h55);
        send_byte(8'h22);
        send_byte(8'h10);
        check("after_tmo_sp2", 32'(o_setpt2), 32'h10);
        idle(2);

        // Get right encoder with 55 21 00 injected during the reply
        i_enc_cnt_r = 24'hABCDEF;
        base_err = err_seen;
        send_byte(8'h55);
        send_byte(8'h25);
        reply_step("r0", 8'h55, 1'b1, 8'h55);
        reply_step("r1", 8'h25, 1'b1, 8'h21);
        reply_step("r2", 8'hAB, 1'b1, 8'h00);
        reply_step("r3", 8'hCD, 1'b0, 8'h00);
        reply_step("r4", 8'hEF, 1'b0, 8'h00);
        check("r_done_busy", 32'(o_busy), 32'd0);
        idle(2);
        check("inject_errs", 32'(err_seen - base_err), 32'd3);
        check("inject_sp1", 32'(o_setpt1), 32'hC0);

        // Reset in the middle of a reply
        i_enc_cnt_l = 24'h000102;
        send_byte(8'h55);
        send_byte(8'h24);
        reply_step("m0", 8'h55, 1'b0, 8'h00);
        check("m1_dv", 32'(o_tx_dv), 32'd1);
        check("m1_byte", 32'(o_tx_byte), 32'h24);
        @(negedge clk_100MHz);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        base_dv = dv_seen;
        pulse_done();
        idle(2);
        pulse_done();
        idle(2);
        check("mid_rst_no_dv", 32'(dv_seen - base_dv), 32'd0);
        check("mid_rst_sp1", 32'(o_setpt1), 32'h80);
        check("mid_rst_tics", 32'(o_tics_per_rev), 32'h0);
        check("mid_rst_tx_byte", 32'(o_tx_byte), 32'h0);
        rst_n = 1'b1;
        idle(3);
        check("post_rst_no_dv", 32'(dv_seen - base_dv), 32'd0);
        check("post_rst_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
